// File: rtl/max_q_selector.sv
// Greedy-action selector: tracks the largest IEEE-754 single Q-value of each
// serial vector and emits it with its index. Optional MAX_Q_NAN_FLAG_EN adds o_nan.
module max_q_selector #(
  parameter int unsigned DATA_WIDTH            = 32,
  parameter int unsigned NUMBER_OF_OUTPUT_NODE = 3,
  parameter int unsigned ACTION_WIDTH          = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_flush,
  output logic [DATA_WIDTH-1:0]   o_max_q,
  output logic [ACTION_WIDTH-1:0] o_action,
  output logic                    o_valid
`ifdef MAX_Q_NAN_FLAG_EN
  , output logic                  o_nan
`endif
);

  localparam int unsigned MAN_W = 23;
  localparam logic [ACTION_WIDTH-1:0] LAST_IDX = ACTION_WIDTH'(NUMBER_OF_OUTPUT_NODE - 1);

  function automatic logic is_nan(input logic [DATA_WIDTH-1:0] w);
    return (&w[DATA_WIDTH-2:MAN_W]) && (|w[MAN_W-1:0]);
  endfunction

  // Monotonic unsigned key; both zeros map to the same key.
  function automatic logic [DATA_WIDTH-1:0] to_key(input logic [DATA_WIDTH-1:0] w);
    logic [DATA_WIDTH-1:0] k;
    if (w[DATA_WIDTH-2:0] == '0)  k = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else if (w[DATA_WIDTH-1])     k = ~w;
    else                          k = {1'b1, w[DATA_WIDTH-2:0]};
    return k;
  endfunction

  logic [ACTION_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   run_max_q, run_max_d;
  logic [ACTION_WIDTH-1:0] run_idx_q, run_idx_d;
  logic [DATA_WIDTH-1:0]   max_out_q, max_out_d;
  logic [ACTION_WIDTH-1:0] act_out_q, act_out_d;
  logic                    valid_q, valid_d;
  logic                    in_nan_c, run_nan_c, greater_c;

  assign in_nan_c  = is_nan(i_data);
  assign run_nan_c = is_nan(run_max_q);
  assign greater_c = to_key(i_data) > to_key(run_max_q);

  // A NaN running max can only be the index-0 word; any later non-NaN displaces it.
  always_comb begin
    cnt_d     = cnt_q;
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    max_out_d = max_out_q;
    act_out_d = act_out_q;
    valid_d   = 1'b0;
    if (i_flush) begin
      cnt_d     = '0;
      run_max_d = '0;
      run_idx_d = '0;
    end else if (i_valid) begin
      if (cnt_q == '0) begin
        run_max_d = i_data;
        run_idx_d = '0;
      end else if (!in_nan_c && (run_nan_c || greater_c)) begin
        run_max_d = i_data;
        run_idx_d = cnt_q;
      end
      if (cnt_q == LAST_IDX) begin
        cnt_d     = '0;
        valid_d   = 1'b1;
        max_out_d = run_max_d;
        act_out_d = run_idx_d;
      end else begin
        cnt_d = cnt_q + ACTION_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      run_max_q <= '0;
      run_idx_q <= '0;
      max_out_q <= '0;
      act_out_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      max_out_q <= max_out_d;
      act_out_q <= act_out_d;
      valid_q   <= valid_d;
    end
  end

  assign o_max_q  = max_out_q;
  assign o_action = act_out_q;
  assign o_valid  = valid_q;

`ifdef MAX_Q_NAN_FLAG_EN
  logic nan_acc_q, nan_acc_d;
  logic nan_out_q, nan_out_d;

  // Sticky per-vector NaN flag, latched into the output with the result.
  always_comb begin
    nan_acc_d = nan_acc_q;
    nan_out_d = nan_out_q;
    if (i_flush) begin
      nan_acc_d = 1'b0;
      nan_out_d = 1'b0;
    end else if (i_valid) begin
      nan_acc_d = (cnt_q == '0) ? in_nan_c : (nan_acc_q | in_nan_c);
      if (cnt_q == LAST_IDX) nan_out_d = nan_acc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nan_acc_q <= 1'b0;
      nan_out_q <= 1'b0;
    end else begin
      nan_acc_q <= nan_acc_d;
      nan_out_q <= nan_out_d;
    end
  end

  assign o_nan = nan_out_q;
`endif

endmodule
